// File: rtl/btn_event_scheduler.sv
// Button event scheduler: latches one-cycle press pulses as per-button pending flags and
// serialises them round-robin into a first-word-fall-through event FIFO.
module btn_event_scheduler #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pulse_in,
    input  logic             evt_ready,
    input  logic             clear_ovf,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] pending,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] grant_oh, drop;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  last_q;
    logic             pop;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    int unsigned      cand;
    int unsigned      n_drop;
    int unsigned      cnt_sum;

    // Round-robin search starting just after the last granted button; the full check uses the
    // registered count so a same-cycle pop never frees a slot early.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        cand      = 0;
        if (count_q < (PTR_W + 1)'(FIFO_DEPTH)) begin
            for (int k = 1; k <= int'(N_BTN); k++) begin
                cand = (int'(last_q) + k) % N_BTN;
                if (!grant_vld && pending_q[cand]) begin
                    grant_vld      = 1'b1;
                    grant_id       = ID_W'(cand);
                    grant_oh[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop      = pulse_in & pending_q & ~grant_oh;
        pending_d = pulse_in | (pending_q & ~grant_oh);
        n_drop    = 0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            n_drop = n_drop + {31'd0, drop[i]};
        end
        // A drop on the same edge as a clear wins: count restarts from this cycle's drops.
        cnt_sum    = (clear_ovf ? 0 : {24'd0, drop_cnt_q}) + n_drop;
        drop_cnt_d = (cnt_sum > 255) ? 8'hff : cnt_sum[7:0];
        overflow_d = (|drop) | (overflow_q & ~clear_ovf);
    end

    always_comb begin
        pop     = (count_q != '0) && evt_ready;
        count_d = count_q;
        if (grant_vld && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!grant_vld && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            last_q     <= ID_W'(N_BTN - 1);
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (grant_vld) begin
                last_q <= grant_id;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are gated by evt_valid.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            mem[wptr_q] <= grant_id;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_id    = evt_valid ? mem[rptr_q] : '0;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Self-checking bench for btn_event_scheduler: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_btn_event_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pulse_in = '0;
    logic         evt_ready = 1'b0;
    logic         clear_ovf = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] pending;
    logic         overflow;
    logic [7:0]   drop_cnt;

    btn_event_scheduler #(.N_BTN(N), .ID_W(2), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .evt_ready (evt_ready),
        .clear_ovf (clear_ovf),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of IDs, pending as a bit vector.
    int       mq[$];
    bit [N-1:0] mpend;
    int       mlast;
    int       mcnt;
    bit       movf;

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        int nd;
        bit do_pop;
        if (!rst_n) begin
            mq.delete();
            mpend = '0;
            mlast = N - 1;
            mcnt  = 0;
            movf  = 0;
        end else begin
            g = -1;
            if (mq.size() < D) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && mpend[(mlast + k) % N]) g = (mlast + k) % N;
                end
            end
            do_pop = (mq.size() > 0) && evt_ready;
            nd = 0;
            for (int i = 0; i < N; i++) begin
                if (pulse_in[i] && mpend[i] && i != g) nd++;
            end
            for (int i = 0; i < N; i++) begin
                mpend[i] = pulse_in[i] || (mpend[i] && i != g);
            end
            if (do_pop) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back(g);
                mlast = g;
            end
            mcnt = clear_ovf ? nd : mcnt + nd;
            if (mcnt > 255) mcnt = 255;
            movf = (nd > 0) || (movf && !clear_ovf);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(evt_valid), int'(mq.size() > 0));
            if (mq.size() > 0) chk("id", int'(evt_id), mq[0]);
            chk("pending", int'(pending), int'(mpend));
            chk("overflow", int'(overflow), int'(movf));
            chk("drop_cnt", int'(drop_cnt), mcnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pulse_in  = '1;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;
        step();
        step();
        pulse_in = '0;
        rst_n    = 1'b1;
        chk("rst_pending", int'(pending), 0);
        chk("rst_valid", int'(evt_valid), 0);
    endtask

    int exp_seq[4];

    initial begin
        do_reset();
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Single press, 2-cycle latency
        evt_ready = 1'b1;
        pulse_in  = 4'b0100;
        step();
        pulse_in = '0;
        chk("single_pend", int'(pending), 4);
        chk("single_valid0", int'(evt_valid), 0);
        step();
        chk("single_valid1", int'(evt_valid), 1);
        chk("single_id", int'(evt_id), 2);
        chk("single_pend_clr", int'(pending), 0);
        step();
        chk("single_valid2", int'(evt_valid), 0);
        chk("single_ovf", int'(overflow), 0);

        // Simultaneous presses drain in order 0..3
        do_reset();
        evt_ready = 1'b1;
        pulse_in  = 4'b1111;
        step();
        pulse_in = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("simul_valid", int'(evt_valid), 1);
            chk("simul_id", int'(evt_id), k);
        end

        // Round-robin after last grant = 1
        do_reset();
        evt_ready = 1'b1;
        pulse_in  = 4'b0010;
        step();
        pulse_in = '0;
        step();
        chk("rr_first", int'(evt_id), 1);
        pulse_in = 4'b0101;
        step();
        pulse_in = '0;
        step();
        chk("rr_id_a", int'(evt_id), 2);
        step();
        chk("rr_id_b", int'(evt_id), 0);

        // Backpressure: fill FIFO, then a merge drop
        do_reset();
        for (int b = 0; b < 4; b++) begin
            pulse_in = 4'(1 << b);
            step();
        end
        pulse_in = 4'b0001;
        step();
        step();
        pulse_in = '0;
        chk("bp_ovf", int'(overflow), 1);
        chk("bp_drop", int'(drop_cnt), 1);
        chk("bp_pend", int'(pending), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_id", int'(evt_id), 0);
        end
        exp_seq = '{1, 2, 3, 0};
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_seq", int'(evt_id), exp_seq[k]);
        end

        // Saturation and clear
        do_reset();
        pulse_in = 4'b1111;
        repeat (100) step();
        chk("sat_cnt", int'(drop_cnt), 255);
        pulse_in  = '0;
        clear_ovf = 1'b1;
        step();
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_cnt", int'(drop_cnt), 0);
        pulse_in = 4'b0001;
        step();
        clear_ovf = 1'b0;
        pulse_in  = '0;
        chk("clr_drop_ovf", int'(overflow), 1);
        chk("clr_drop_cnt", int'(drop_cnt), 1);

        // Reset mid-operation
        do_reset();
        pulse_in = 4'b0111;
        step();
        pulse_in = '0;
        repeat (3) step();
        pulse_in = 4'b1010;
        step();
        pulse_in = '0;
        chk("mid_pend", int'(pending), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", int'(evt_valid), 0);
        chk("mid_id", int'(evt_id), 0);
        chk("mid_pending", int'(pending), 0);
        chk("mid_ovf", int'(overflow), 0);
        chk("mid_cnt", int'(drop_cnt), 0);
        step();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        pulse_in  = 4'b1001;
        step();
        pulse_in = '0;
        step();
        chk("mid_prio", int'(evt_id), 0);

        // Randomized soak, varying consumer bias per segment
        for (int seg = 0; seg < 6; seg++) begin
            repeat (500) begin
                pulse_in  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
                evt_ready = ($urandom_range(0, 5) < seg);
                clear_ovf = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end
                step();
            end
        end

        pulse_in  = '0;
        clear_ovf = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
